// File: rtl/s2p_nibble_fifo_if.sv
// s2p_nibble_fifo_if: serial bit input and buffered word output bus of the deserializer FIFO
interface s2p_nibble_fifo_if #(
  parameter int DW = 4,
  parameter int AW = 2
);
  logic          din;
  logic          din_vld;
  logic          sync_clr;
  logic          dout_rdy;
  logic          ovf_clr;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic [AW:0]   level;
  logic          ovf;
  modport master(output din, din_vld, sync_clr, dout_rdy, ovf_clr, input dout, dout_vld, level, ovf);
  modport slave(input din, din_vld, sync_clr, dout_rdy, ovf_clr, output dout, dout_vld, level, ovf);
endinterface

// File: rtl/s2p_nibble_fifo.sv
// s2p_nibble_fifo: reassembles serial bits into DW-bit words buffered in a FWFT FIFO with sticky overflow
module s2p_nibble_fifo #(
  parameter int DW        = 4,
  parameter int DEPTH     = 4,
  parameter int AW        = 2,
  parameter int MSB_FIRST = 1
) (
  input logic clk,
  input logic rst,
  s2p_nibble_fifo_if.slave bus
);
  localparam int CW = $clog2(DW);
  logic [CW-1:0] cnt;
  logic [DW-1:0] sr;
  logic [DW-1:0] word;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          ovf;
  logic          last;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  // the shift register always holds the word-so-far, so the complete word is one more shift
  always_comb word = MSB_FIRST != 0 ? {sr[DW-2:0], bus.din} : {bus.din, sr[DW-1:1]};
  assign last  = cnt == CW'(DW - 1);
  assign push  = bus.din_vld && !bus.sync_clr && last;
  assign pop   = level != '0 && bus.dout_rdy;
  assign full  = level == (AW+1)'(DEPTH);
  assign wr_en = push && (!full || pop);
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr] <= word;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      sr     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (bus.sync_clr) begin
        cnt <= '0;
        sr  <= '0;
      end else if (bus.din_vld) begin
        cnt <= last ? '0 : cnt + 1'b1;
        sr  <= word;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(wr_en) - (AW+1)'(pop);
      ovf   <= (push && full && !pop) || (ovf && !bus.ovf_clr);
    end
  end
  assign bus.dout     = level != '0 ? mem[rd_ptr] : '0;
  assign bus.dout_vld = level != '0;
  assign bus.level    = level;
  assign bus.ovf      = ovf;
endmodule

// File: tb/tb_s2p_nibble_fifo.sv
// tb_s2p_nibble_fifo: directed and randomized checks of MSB-first and LSB-first instances against a queue model
module tb_s2p_nibble_fifo;
  logic clk = 0, rst = 0, din = 0, din_vld = 0, sync_clr = 0, dout_rdy = 0, ovf_clr = 0;
  int errors = 0, checks = 0;
  int nb, pa, pb;
  logic [3:0] qa[$], qb[$];
  bit movf;
  always #5 clk = ~clk;
  s2p_nibble_fifo_if #(.DW(4), .AW(2)) ia();
  s2p_nibble_fifo_if #(.DW(4), .AW(2)) ib();
  assign ia.din = din;
  assign ia.din_vld = din_vld;
  assign ia.sync_clr = sync_clr;
  assign ia.dout_rdy = dout_rdy;
  assign ia.ovf_clr = ovf_clr;
  assign ib.din = din;
  assign ib.din_vld = din_vld;
  assign ib.sync_clr = sync_clr;
  assign ib.dout_rdy = dout_rdy;
  assign ib.ovf_clr = ovf_clr;
  s2p_nibble_fifo #(.DW(4), .DEPTH(4), .AW(2), .MSB_FIRST(1)) ua (.clk(clk), .rst(rst), .bus(ia.slave));
  s2p_nibble_fifo #(.DW(4), .DEPTH(4), .AW(2), .MSB_FIRST(0)) ub (.clk(clk), .rst(rst), .bus(ib.slave));

  // word value built arithmetically: MSB-first doubles-and-adds, LSB-first weights bit n by 2**n
  task automatic tick();
    bit pop, full, push;
    int wa, wb;
    pop = qa.size() != 0 && dout_rdy;
    full = qa.size() == 4;
    push = 0;
    wa = 0;
    wb = 0;
    if (rst) begin
      nb = 0; pa = 0; pb = 0; movf = 0;
      qa.delete(); qb.delete();
    end else begin
      if (sync_clr) begin
        nb = 0; pa = 0; pb = 0;
      end else if (din_vld) begin
        wa = (pa * 2 + int'(din)) % 16;
        wb = pb + (int'(din) << nb);
        if (nb == 3) begin push = 1; nb = 0; pa = 0; pb = 0; end
        else begin nb++; pa = wa; pb = wb; end
      end
      movf = (push && full && !pop) || (movf && !ovf_clr);
      if (pop) begin void'(qa.pop_front()); void'(qb.pop_front()); end
      if (push && (!full || pop)) begin qa.push_back(4'(wa)); qb.push_back(4'(wb)); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    din = b;
    din_vld = 1;
    tick();
    din_vld = 0;
  endtask

  task automatic send(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) bit_in(w[i]);
  endtask

  task automatic reset_dut();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks += 4;
    if (ia.level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", ia.level); end
    if (ia.dout_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", ia.dout_vld); end
    if (ia.dout !== 4'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", ia.dout); end
    if (ia.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ia.ovf); end
  endtask

  task automatic test_stream(input bit gaps);
    logic [15:0] s;
    logic [3:0] ea[4], eb[4];
    s = 16'h0132;
    ea = '{4'h0, 4'h1, 4'h3, 4'h2};
    eb = '{4'h0, 4'h8, 4'hC, 4'h4};
    reset_dut();
    dout_rdy = 1;
    for (int i = 0; i < 16; i++) begin
      bit_in(s[15-i]);
      checks += 2;
      if (ia.dout_vld !== (i % 4 == 3)) begin errors++; $display("FAIL stream_vld bit %0d gaps %0d: got %b expected %b", i, gaps, ia.dout_vld, i % 4 == 3); end
      if (ia.level > 1) begin errors++; $display("FAIL stream_level bit %0d: got %0d expected <=1", i, ia.level); end
      if (i % 4 == 3) begin
        checks += 2;
        if (ia.dout !== ea[i/4]) begin errors++; $display("FAIL stream_dout_msb word %0d: got %h expected %h", i / 4, ia.dout, ea[i/4]); end
        if (ib.dout !== eb[i/4]) begin errors++; $display("FAIL stream_dout_lsb word %0d: got %h expected %h", i / 4, ib.dout, eb[i/4]); end
      end
      if (gaps) begin
        tick();
        checks++;
        if (ia.dout_vld !== 1'b0) begin errors++; $display("FAIL stream_gap_vld bit %0d: got %b expected 0", i, ia.dout_vld); end
      end
    end
    tick();
    checks += 2;
    if (ia.dout_vld !== 1'b0) begin errors++; $display("FAIL stream_end_vld: got %b expected 0", ia.dout_vld); end
    if (ia.ovf !== 1'b0) begin errors++; $display("FAIL stream_ovf: got %b expected 0", ia.ovf); end
    dout_rdy = 0;
  endtask

  task automatic test_overflow();
    reset_dut();
    dout_rdy = 0;
    for (int w = 1; w <= 5; w++) begin
      send(4'(w));
      if (w == 4) begin
        checks += 2;
        if (ia.level !== 3'd4) begin errors++; $display("FAIL ovf_fill_level: got %0d expected 4", ia.level); end
        if (ia.ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ia.ovf); end
      end
    end
    checks += 2;
    if (ia.level !== 3'd4) begin errors++; $display("FAIL ovf_drop_level: got %0d expected 4", ia.level); end
    if (ia.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ia.ovf); end
    dout_rdy = 1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (ia.dout !== 4'(k)) begin errors++; $display("FAIL ovf_drain %0d: got %h expected %h", k, ia.dout, k); end
      tick();
    end
    dout_rdy = 0;
    checks += 4;
    if (ia.level !== 3'd0) begin errors++; $display("FAIL ovf_empty_level: got %0d expected 0", ia.level); end
    if (ia.dout_vld !== 1'b0) begin errors++; $display("FAIL ovf_empty_vld: got %b expected 0", ia.dout_vld); end
    if (ia.dout !== 4'h0) begin errors++; $display("FAIL ovf_empty_dout: got %h expected 0", ia.dout); end
    if (ia.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ia.ovf); end
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    checks++;
    if (ia.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", ia.ovf); end
  endtask

  task automatic test_full_pop();
    logic [3:0] e[4];
    e = '{4'h7, 4'h8, 4'h9, 4'hA};
    reset_dut();
    dout_rdy = 0;
    for (int w = 6; w <= 9; w++) send(4'(w));
    bit_in(1); bit_in(0); bit_in(1);
    dout_rdy = 1;
    bit_in(0);
    checks += 2;
    if (ia.level !== 3'd4) begin errors++; $display("FAIL fullpop_level: got %0d expected 4", ia.level); end
    if (ia.ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b expected 0", ia.ovf); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ia.dout !== e[k]) begin errors++; $display("FAIL fullpop_drain %0d: got %h expected %h", k, ia.dout, e[k]); end
      tick();
    end
    dout_rdy = 0;
    reset_dut();
    for (int w = 0; w < 4; w++) send(4'hF);
    bit_in(1); bit_in(1); bit_in(1);
    ovf_clr = 1;
    bit_in(1);
    ovf_clr = 0;
    checks += 2;
    if (ia.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", ia.ovf); end
    if (ia.level !== 3'd4) begin errors++; $display("FAIL ovf_set_wins_level: got %0d expected 4", ia.level); end
  endtask

  task automatic test_sync_clr();
    reset_dut();
    dout_rdy = 0;
    bit_in(1); bit_in(1);
    sync_clr = 1; din = 1; din_vld = 1;
    tick();
    sync_clr = 0; din_vld = 0;
    bit_in(0); bit_in(1); bit_in(0); bit_in(1);
    checks += 3;
    if (ia.level !== 3'd1) begin errors++; $display("FAIL sync_level: got %0d expected 1", ia.level); end
    if (ia.dout !== 4'h5) begin errors++; $display("FAIL sync_dout_msb: got %h expected 5", ia.dout); end
    if (ib.dout !== 4'hA) begin errors++; $display("FAIL sync_dout_lsb: got %h expected a", ib.dout); end
    bit_in(1); bit_in(1); bit_in(1);
    sync_clr = 1; din = 1; din_vld = 1;
    tick();
    sync_clr = 0; din_vld = 0;
    checks++;
    if (ia.level !== 3'd1) begin errors++; $display("FAIL sync_last_nopush: got %0d expected 1", ia.level); end
    bit_in(0); bit_in(0); bit_in(1); bit_in(1);
    checks++;
    if (ia.level !== 3'd2) begin errors++; $display("FAIL sync_restart: got %0d expected 2", ia.level); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    dout_rdy = 0;
    send(4'h1); send(4'h2); send(4'h3);
    bit_in(1); bit_in(1);
    rst = 1; din_vld = 1; dout_rdy = 1;
    tick();
    rst = 0; din_vld = 0; dout_rdy = 0;
    checks += 4;
    if (ia.level !== 3'd0) begin errors++; $display("FAIL rstmid_level: got %0d expected 0", ia.level); end
    if (ia.dout_vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld: got %b expected 0", ia.dout_vld); end
    if (ia.dout !== 4'h0) begin errors++; $display("FAIL rstmid_dout: got %h expected 0", ia.dout); end
    if (ia.ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b expected 0", ia.ovf); end
    bit_in(1); bit_in(0); bit_in(0); bit_in(1);
    checks += 2;
    if (ia.dout !== 4'h9) begin errors++; $display("FAIL rstmid_msb9: got %h expected 9", ia.dout); end
    if (ib.dout !== 4'h9) begin errors++; $display("FAIL rstmid_lsb9: got %h expected 9", ib.dout); end
    dout_rdy = 1;
    tick();
    dout_rdy = 0;
    bit_in(1); bit_in(0); bit_in(0); bit_in(0);
    checks += 2;
    if (ia.dout !== 4'h8) begin errors++; $display("FAIL rstmid_msb8: got %h expected 8", ia.dout); end
    if (ib.dout !== 4'h1) begin errors++; $display("FAIL rstmid_lsb1: got %h expected 1", ib.dout); end
  endtask

  task automatic test_random();
    logic [3:0] ha, hb;
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 249) == 0;
      din = 1'($urandom);
      din_vld = $urandom_range(0, 3) != 0;
      sync_clr = $urandom_range(0, 29) == 0;
      dout_rdy = (c / 500) % 2 == 0 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      ovf_clr = $urandom_range(0, 19) == 0;
      tick();
      ha = qa.size() != 0 ? qa[0] : 4'h0;
      hb = qb.size() != 0 ? qb[0] : 4'h0;
      checks += 6;
      if (ia.level !== 3'(qa.size())) begin errors++; $display("FAIL rand_level cyc %0d: got %0d expected %0d", c, ia.level, qa.size()); end
      if (ia.dout_vld !== (qa.size() != 0)) begin errors++; $display("FAIL rand_vld cyc %0d: got %b expected %b", c, ia.dout_vld, qa.size() != 0); end
      if (ia.dout !== ha) begin errors++; $display("FAIL rand_dout_msb cyc %0d: got %h expected %h", c, ia.dout, ha); end
      if (ib.dout !== hb) begin errors++; $display("FAIL rand_dout_lsb cyc %0d: got %h expected %h", c, ib.dout, hb); end
      if (ia.ovf !== movf) begin errors++; $display("FAIL rand_ovf_msb cyc %0d: got %b expected %b", c, ia.ovf, movf); end
      if (ib.ovf !== movf) begin errors++; $display("FAIL rand_ovf_lsb cyc %0d: got %b expected %b", c, ib.ovf, movf); end
    end
    rst = 0; din_vld = 0; sync_clr = 0; dout_rdy = 0; ovf_clr = 0;
  endtask

  initial begin
    #1;
    test_reset();
    test_stream(0);
    test_stream(1);
    test_overflow();
    test_full_pop();
    test_sync_clr();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
